// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between the upstream FIFO and the I2S transmitter.
// Transfer happens on a bit-clock edge where s_valid && s_ready.
interface i2s_tx_serializer_if #(
    parameter int unsigned I2S_WIDTH = 24
);
    logic [I2S_WIDTH-1:0] s_left;
    logic [I2S_WIDTH-1:0] s_right;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_left,
        output s_right,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_left,
        input  s_right,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S (Philips) master transmitter: one-bit delay, MSB first, fixed-width slots.
// A single holding register decouples the handshake from frame-aligned word latching.
module i2s_tx_serializer #(
    parameter int unsigned I2S_WIDTH = 24,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic               i2s_bclk,
    input  logic               sys_rst,
    i2s_tx_serializer_if.slave s_bus,
    output logic               i2s_lrclk,
    output logic               i2s_data,
    output logic               frame_start,
    output logic               underrun
);
    localparam int unsigned    CntW    = $clog2(SLOT_BITS);
    localparam logic [CntW-1:0] LastBit = CntW'(SLOT_BITS - 1);

    logic                 r_ch;
    logic [CntW-1:0]      r_bit_cnt;
    logic                 r_hold_full;
    logic [I2S_WIDTH-1:0] r_hold_l;
    logic [I2S_WIDTH-1:0] r_hold_r;
    logic [I2S_WIDTH-1:0] r_tx_r;
    logic [I2S_WIDTH-1:0] r_shift;
    logic                 r_lrclk;
    logic                 r_data;
    logic                 r_frame_start;
    logic                 r_underrun;

    logic                 w_wrap;
    logic                 w_boundary;
    logic                 w_accept;
    logic                 w_ch_nxt;
    logic [CntW-1:0]      w_bit_nxt;
    logic                 w_hold_full_nxt;
    logic [I2S_WIDTH-1:0] w_hold_l_nxt;
    logic [I2S_WIDTH-1:0] w_hold_r_nxt;
    logic [I2S_WIDTH-1:0] w_tx_l;
    logic [I2S_WIDTH-1:0] w_tx_r;
    logic [I2S_WIDTH-1:0] w_tx_r_nxt;
    logic [I2S_WIDTH-1:0] w_shift_nxt;
    logic                 w_data_nxt;

    always_comb begin
        w_wrap     = (r_bit_cnt == LastBit);
        w_boundary = r_ch && w_wrap;
        w_accept   = s_bus.s_valid && !r_hold_full;
        w_ch_nxt   = r_ch ^ w_wrap;
        w_bit_nxt  = w_wrap ? '0 : r_bit_cnt + CntW'(1);

        // An empty holding register at the boundary sends a silent frame.
        w_tx_l     = r_hold_full ? r_hold_l : '0;
        w_tx_r     = r_hold_full ? r_hold_r : '0;
        w_tx_r_nxt = w_boundary ? w_tx_r : r_tx_r;

        w_hold_full_nxt = r_hold_full;
        w_hold_l_nxt    = r_hold_l;
        w_hold_r_nxt    = r_hold_r;
        if (w_boundary) begin
            w_hold_full_nxt = 1'b0;
        end
        // Accept at the boundary is only possible when empty: it fills holding, no bypass.
        if (w_accept) begin
            w_hold_full_nxt = 1'b1;
            w_hold_l_nxt    = s_bus.s_left;
            w_hold_r_nxt    = s_bus.s_right;
        end

        // Load at slot bit 0 (the delay bit); the MSB leaves on bit 1, zeros after the LSB.
        if (w_bit_nxt == '0) begin
            w_shift_nxt = w_ch_nxt ? r_tx_r : w_tx_l;
            w_data_nxt  = 1'b0;
        end else begin
            w_shift_nxt = r_shift << 1;
            w_data_nxt  = r_shift[I2S_WIDTH-1];
        end
    end

    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ch          <= 1'b1;
            r_bit_cnt     <= LastBit;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_tx_r        <= '0;
            r_shift       <= '0;
            r_lrclk       <= 1'b1;
            r_data        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_ch          <= w_ch_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_hold_full   <= w_hold_full_nxt;
            r_hold_l      <= w_hold_l_nxt;
            r_hold_r      <= w_hold_r_nxt;
            r_tx_r        <= w_tx_r_nxt;
            r_shift       <= w_shift_nxt;
            r_lrclk       <= w_ch_nxt;
            r_data        <= w_data_nxt;
            r_frame_start <= w_boundary;
            r_underrun    <= w_boundary && !r_hold_full;
        end
    end

    assign s_bus.s_ready = !r_hold_full;
    assign i2s_lrclk     = r_lrclk;
    assign i2s_data      = r_data;
    assign frame_start   = r_frame_start;
    assign underrun      = r_underrun;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomised bench for i2s_tx_serializer against a frame-level reference model
// that derives every expected output from the cycle position since reset.
module tb_i2s_tx_serializer;
    localparam int W    = 24;
    localparam int SLOT = 32;
    localparam int FRM  = 2 * SLOT;

    logic i2s_bclk = 1'b0;
    logic sys_rst  = 1'b1;
    logic i2s_lrclk;
    logic i2s_data;
    logic frame_start;
    logic underrun;

    i2s_tx_serializer_if #(.I2S_WIDTH(W)) bus ();

    i2s_tx_serializer #(
        .I2S_WIDTH(W),
        .SLOT_BITS(SLOT)
    ) dut (
        .i2s_bclk   (i2s_bclk),
        .sys_rst    (sys_rst),
        .s_bus      (bus),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_data   (i2s_data),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 i2s_bclk = ~i2s_bclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k counts posedges since reset release; the frame position is (k-1) mod 64.
    int           k = 0;
    int           p = FRM - 1;
    logic         m_held = 1'b0;
    logic         m_acc  = 1'b0;
    logic [W-1:0] m_hl = '0, m_hr = '0;
    logic [W-1:0] cur_l = '0, cur_r = '0;
    logic         exp_fs = 1'b0, exp_ur = 1'b0;
    logic [W-1:0] rx = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step();
        logic         c;
        int           b;
        logic [W-1:0] word;
        logic         exp_d;
        @(posedge i2s_bclk);
        k++;
        p      = (k - 1) % FRM;
        m_acc  = bus.s_valid && !m_held;
        exp_fs = (p == 0);
        exp_ur = 1'b0;
        if (p == 0) begin
            exp_ur = !m_held;
            cur_l  = m_held ? m_hl : '0;
            cur_r  = m_held ? m_hr : '0;
            m_held = 1'b0;
        end
        if (m_acc) begin
            m_hl   = bus.s_left;
            m_hr   = bus.s_right;
            m_held = 1'b1;
        end
        @(negedge i2s_bclk);
        c     = (p >= SLOT);
        b     = p % SLOT;
        word  = c ? cur_r : cur_l;
        exp_d = (b >= 1 && b <= W) ? word[W-b] : 1'b0;
        check_eq("lrclk", i2s_lrclk, c);
        check_eq("data", i2s_data, exp_d);
        check_eq("frame_start", frame_start, exp_fs);
        check_eq("underrun", underrun, exp_ur);
        check_eq("s_ready", bus.s_ready, !m_held);
        if (b == 0) rx = '0;
        else if (b <= W) rx = {rx[W-2:0], i2s_data};
        if (b == SLOT - 1) check_eq(c ? "word_r" : "word_l", rx, word);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        logic done = 1'b0;
        bus.s_left  = l;
        bus.s_right = r;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3 * FRM && !done; i++) begin
            step();
            done = m_acc;
        end
        bus.s_valid = 1'b0;
        check_eq("send_accepted", done, 1'b1);
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < FRM && p != target; i++) step();
        check_eq("pos_reached", p, target);
    endtask

    initial begin
        logic [W-1:0] v;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;
        repeat (3) @(negedge i2s_bclk);
        check_eq("rst_ready", bus.s_ready, 1'b1);
        check_eq("rst_lrclk", i2s_lrclk, 1'b1);
        check_eq("rst_data", i2s_data, 1'b0);
        check_eq("rst_fs", frame_start, 1'b0);
        check_eq("rst_ur", underrun, 1'b0);
        sys_rst = 1'b0;

        run(3 * FRM);

        send_pair(24'hA5C3F0, 24'h0F1E2D);
        run(2 * FRM);

        // Back-to-back with valid held high.
        v           = 24'd1;
        bus.s_left  = v;
        bus.s_right = v + 24'h100000;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5 * FRM; i++) begin
            step();
            if (m_acc) begin
                v           = v + 24'd1;
                bus.s_left  = v;
                bus.s_right = v + 24'h100000;
            end
        end
        bus.s_valid = 1'b0;
        run(2 * FRM);

        // Accept on the boundary cycle with holding empty.
        wait_pos(FRM - 1);
        bus.s_left  = 24'h123456;
        bus.s_right = 24'h654321;
        bus.s_valid = 1'b1;
        check_eq("ready_at_boundary", bus.s_ready, 1'b1);
        step();
        bus.s_valid = 1'b0;
        check_eq("boundary_accept", m_acc, 1'b1);
        check_eq("boundary_ur", underrun, 1'b1);
        run(2 * FRM);

        send_pair(24'h800001, 24'h7FFFFE);
        run(2 * FRM);

        // Random traffic; valid stays up until accepted.
        for (int i = 0; i < 16 * FRM; i++) begin
            step();
            if (m_acc) bus.s_valid = 1'b0;
            if (!bus.s_valid && $urandom_range(0, 3) == 0) begin
                bus.s_left  = W'($urandom);
                bus.s_right = W'($urandom);
                bus.s_valid = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        run(2 * FRM);

        // Reset at right-slot bit 10 with a pair held.
        wait_pos(0);
        send_pair(24'hDEADBE, 24'hCAFE01);
        wait_pos(SLOT + 10);
        check_eq("held_before_rst", bus.s_ready, 1'b0);
        sys_rst = 1'b1;
        #1;
        check_eq("midrst_lrclk", i2s_lrclk, 1'b1);
        check_eq("midrst_data", i2s_data, 1'b0);
        check_eq("midrst_ready", bus.s_ready, 1'b1);
        check_eq("midrst_fs", frame_start, 1'b0);
        repeat (3) @(negedge i2s_bclk);
        k      = 0;
        p      = FRM - 1;
        m_held = 1'b0;
        cur_l  = '0;
        cur_r  = '0;
        sys_rst = 1'b0;
        step();
        check_eq("post_rst_ur", underrun, 1'b1);
        run(2 * FRM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- I2S master transmitter in the i2s_bclk domain. Serialises stereo 24-bit sample pairs into standard I2S (Philips, one-bit delay, MSB first, 32-bit slots) and generates the word-select clock.
- Sits directly upstream of the I2S receiver stage and drives its i2s_lrclk/i2s_data inputs. Used for on-chip loopback and as the codec-side output path.
- Sample pairs arrive via a valid/ready handshake already in the bclk domain. CDC is handled by the upstream FIFO.

Parameters:
- I2S_WIDTH, 24, sample bits per channel; must satisfy I2S_WIDTH <= SLOT_BITS-1.
- SLOT_BITS, 32, bclk cycles per channel slot; frame = 2*SLOT_BITS cycles.

Ports:
- i2s_bclk  input  1  bit clock; all logic on posedge.
- sys_rst  input  1  asynchronous, active-high reset.
- s_left  input  I2S_WIDTH  left sample, two's complement.
- s_right  input  I2S_WIDTH  right sample, two's complement.
- s_valid  input  1  sample pair valid.
- s_ready  output  1  holding register empty; transfer when s_valid && s_ready.
- i2s_lrclk  output  1  word select: 0 = left slot, 1 = right slot.
- i2s_data  output  1  serial data.
- frame_start  output  1  one-cycle pulse on the first bclk of each left slot.
- underrun  output  1  one-cycle pulse (coincident with frame_start) when no pair was held at the frame boundary.

Behaviour:
- Reset values:
  - Outputs: s_ready=1, i2s_lrclk=1, i2s_data=0, frame_start=0, underrun=0.
  - Internal: ch=1, bit_cnt=SLOT_BITS-1, holding empty, shift registers 0.
  - Effect: the first posedge after reset release is a frame boundary.
- Counters:
  - bit_cnt increments 0..SLOT_BITS-1 each posedge.
  - On wrap, ch toggles.
  - Frame boundary = posedge where (ch=1, bit_cnt=SLOT_BITS-1) advances to (ch=0, bit_cnt=0).
- Registered outputs follow the next-state (c,b) at each posedge:
  - i2s_lrclk = c.
  - i2s_data = 0 for b=0 (one-bit delay slot).
  - i2s_data = bit (I2S_WIDTH-b) of that channel's word for b=1..I2S_WIDTH, i.e. MSB at b=1 and LSB at b=I2S_WIDTH.
  - i2s_data = 0 for b > I2S_WIDTH.
  - The receiver samples on the following posedge. No negedge logic.
- Holding register:
  - s_ready = !hold_full.
  - An accept loads {s_left, s_right} and sets hold_full.
  - s_left/s_right are ignored when not accepted.
- At the frame boundary:
  - If hold_full: copy holding to the left/right transmit words and clear hold_full. s_ready is 1 from the next cycle.
  - If empty: transmit words are all zeros for this frame, and underrun=1 for that cycle.
  - frame_start=1 in both cases.
- Simultaneous accept at the boundary with the holding register empty:
  - The pair is captured into holding only. There is no bypass.
  - The current frame underruns; the pair transmits next frame.
- Words are latched only at the frame boundary. Left and right of one pair always go out in the same frame; the right word is never taken mid-frame.
- Latency: a pair accepted while the holding register is empty is transmitted starting at the next frame boundary.
  - Its left MSB appears on i2s_data 1 cycle after frame_start.
  - Its right MSB appears SLOT_BITS+1 cycles after frame_start.
- Throughput: max one pair per 2*SLOT_BITS cycles. With s_valid held high, s_ready is high exactly one cycle per frame.
- Reset mid-frame: all state returns to reset values immediately. The partial word is abandoned and the holding contents are discarded.

Test Plan:
- Reset, s_valid=0 for 3 frames -> frame_start every 64 cycles; underrun=1 with each; i2s_data constantly 0; lrclk 0 for 32 cycles, then 1 for 32.
- Send left=24'hA5C3F0, right=24'h0F1E2D before the first boundary -> left slot data bits 1..24 = A5C3F0 MSB-first, bits 0 and 25..31 = 0. Right slot carries 0F1E2D. underrun=0.
- Back-to-back pairs with s_valid held high, values 1,2,3,... -> one accept per 64 cycles; consecutive frames carry 1,2,3 in order; no underrun; no pair dropped or repeated.
- s_valid asserted exactly on the boundary cycle with holding empty -> pair accepted (s_ready=1 that cycle); underrun=1; the pair appears in the following frame.
- Loopback into the I2S receiver stage with left=24'h800001, right=24'h7FFFFE -> receiver recovers identical values per channel; sample_valid pulses once per channel word.
- sys_rst asserted at bit_cnt=10 of a right slot with a pair held -> i2s_lrclk=1 and i2s_data=0 immediately. After release, the held pair is not transmitted and the first frame underruns.
